// File: rtl/music_sequencer_pkg.sv
// Shared definitions for the melody sequencer: note codes, frequency table,
// FSM state encoding, song ROM entry layout and the code-to-divider mapping.
`timescale 1ns/1ps
package music_sequencer_pkg;

    localparam int NOTE_DIV_W = 22;
    localparam int IDX_W      = 4;
    localparam int CODE_W     = 4;
    localparam int DUR_W      = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PLAY   = 2'd1,
        ST_GAP    = 2'd2,
        ST_PAUSED = 2'd3
    } state_t;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic [DUR_W-1:0]  dur;
    } rom_entry_t;

    localparam logic [CODE_W-1:0] NOTE_REST = 4'd0;
    localparam logic [CODE_W-1:0] NOTE_C4   = 4'd1;
    localparam logic [CODE_W-1:0] NOTE_D4   = 4'd2;
    localparam logic [CODE_W-1:0] NOTE_E4   = 4'd3;
    localparam logic [CODE_W-1:0] NOTE_F4   = 4'd4;
    localparam logic [CODE_W-1:0] NOTE_G4   = 4'd5;
    localparam logic [CODE_W-1:0] NOTE_A4   = 4'd6;
    localparam logic [CODE_W-1:0] NOTE_B4   = 4'd7;
    localparam logic [CODE_W-1:0] NOTE_C5   = 4'd8;

    localparam int FREQ_C4 = 262;
    localparam int FREQ_D4 = 294;
    localparam int FREQ_E4 = 330;
    localparam int FREQ_F4 = 349;
    localparam int FREQ_G4 = 392;
    localparam int FREQ_A4 = 440;
    localparam int FREQ_B4 = 494;
    localparam int FREQ_C5 = 523;

    function automatic logic is_rest(input logic [CODE_W-1:0] code);
        return (code == NOTE_REST) || (code > NOTE_C5);
    endfunction

    // Every branch is a constant expression, so this folds into a small mux.
    function automatic logic [NOTE_DIV_W-1:0] note_divider(input logic [CODE_W-1:0] code,
                                                           input int clk_hz);
        int d;
        case (code)
            NOTE_C4: d = clk_hz / (2 * FREQ_C4) - 1;
            NOTE_D4: d = clk_hz / (2 * FREQ_D4) - 1;
            NOTE_E4: d = clk_hz / (2 * FREQ_E4) - 1;
            NOTE_F4: d = clk_hz / (2 * FREQ_F4) - 1;
            NOTE_G4: d = clk_hz / (2 * FREQ_G4) - 1;
            NOTE_A4: d = clk_hz / (2 * FREQ_A4) - 1;
            NOTE_B4: d = clk_hz / (2 * FREQ_B4) - 1;
            NOTE_C5: d = clk_hz / (2 * FREQ_C5) - 1;
            default: d = 0;
        endcase
        return NOTE_DIV_W'(d);
    endfunction

endpackage

// File: rtl/music_sequencer_song_rom.sv
// Fixed 16-entry melody table; each entry is a note code and a duration in beats minus one.
`timescale 1ns/1ps
module song_rom
    import music_sequencer_pkg::*;
(
    input  logic [IDX_W-1:0] index,
    output rom_entry_t       entry
);

    always_comb begin
        entry = '{code: NOTE_REST, dur: 2'd0};
        case (index)
            4'd0:  entry = '{code: NOTE_C4,   dur: 2'd0};
            4'd1:  entry = '{code: NOTE_A4,   dur: 2'd1};
            4'd2:  entry = '{code: NOTE_REST, dur: 2'd0};
            4'd3:  entry = '{code: NOTE_E4,   dur: 2'd0};
            4'd4:  entry = '{code: NOTE_F4,   dur: 2'd0};
            4'd5:  entry = '{code: NOTE_G4,   dur: 2'd1};
            4'd6:  entry = '{code: NOTE_G4,   dur: 2'd0};
            4'd7:  entry = '{code: NOTE_A4,   dur: 2'd0};
            4'd8:  entry = '{code: NOTE_G4,   dur: 2'd0};
            4'd9:  entry = '{code: NOTE_F4,   dur: 2'd0};
            4'd10: entry = '{code: NOTE_E4,   dur: 2'd1};
            4'd11: entry = '{code: NOTE_D4,   dur: 2'd0};
            4'd12: entry = '{code: NOTE_E4,   dur: 2'd0};
            4'd13: entry = '{code: NOTE_D4,   dur: 2'd0};
            4'd14: entry = '{code: NOTE_REST, dur: 2'd0};
            4'd15: entry = '{code: NOTE_C5,   dur: 2'd3};
        endcase
    end

endmodule

// File: rtl/music_sequencer.sv
// Melody sequencer: walks the song ROM at the beat rate, inserts a muted gap after
// each note and supports play/pause, stop and looping. All outputs are registered.
`timescale 1ns/1ps
module music_sequencer
    import music_sequencer_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int BEAT_CYCLES = 25_000_000,
    parameter int GAP_CYCLES  = 2_500_000,
    parameter int SONG_LEN    = 16
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  play_pause,
    input  logic                  stop,
    input  logic                  loop_en,
    output logic [NOTE_DIV_W-1:0] note_div,
    output logic                  mute,
    output logic                  playing,
    output logic [IDX_W-1:0]      song_idx,
    output logic                  done
);

    localparam int BEAT_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(SONG_LEN - 1);

    state_t                  state, state_next, saved, saved_next, timed_state;
    logic [BEAT_W-1:0]       beat_cnt, beat_next;
    logic [GAP_W-1:0]        gap_cnt, gap_next;
    logic [DUR_W-1:0]        beats_left, beats_left_next;
    logic [IDX_W-1:0]        idx_next, fetch_idx;
    logic                    load, done_next, cur_mute, cur_mute_next;
    logic [NOTE_DIV_W-1:0]   note_div_next;
    logic                    mute_next, playing_next;
    rom_entry_t              entry;

    // The only entries ever loaded are entry 0 (start/loop) and the successor in GAP.
    always_comb begin
        fetch_idx = '0;
        if (state == ST_GAP && song_idx != LAST_IDX) fetch_idx = song_idx + 1'b1;
    end

    song_rom u_song_rom (
        .index (fetch_idx),
        .entry (entry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            saved      <= ST_IDLE;
            song_idx   <= '0;
            beat_cnt   <= '0;
            gap_cnt    <= '0;
            beats_left <= '0;
            cur_mute   <= 1'b1;
            note_div   <= '0;
            mute       <= 1'b1;
            playing    <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            saved      <= saved_next;
            song_idx   <= idx_next;
            beat_cnt   <= beat_next;
            gap_cnt    <= gap_next;
            beats_left <= beats_left_next;
            cur_mute   <= cur_mute_next;
            note_div   <= note_div_next;
            mute       <= mute_next;
            playing    <= playing_next;
            done       <= done_next;
        end
    end

    // Timing events resolve first; a pause then wraps whatever state they produced.
    always_comb begin
        timed_state     = state;
        state_next      = state;
        saved_next      = saved;
        idx_next        = song_idx;
        beat_next       = beat_cnt;
        gap_next        = gap_cnt;
        beats_left_next = beats_left;
        load            = 1'b0;
        done_next       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (play_pause) begin
                    timed_state = ST_PLAY;
                    idx_next    = '0;
                    load        = 1'b1;
                end
            end
            ST_PLAY: begin
                if (beat_cnt == BEAT_LAST) begin
                    beat_next = '0;
                    if (beats_left == '0) begin
                        timed_state = ST_GAP;
                        gap_next    = '0;
                    end else begin
                        beats_left_next = beats_left - 1'b1;
                    end
                end else begin
                    beat_next = beat_cnt + 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    gap_next = '0;
                    if (song_idx != LAST_IDX || loop_en) begin
                        timed_state = ST_PLAY;
                        idx_next    = fetch_idx;
                        load        = 1'b1;
                    end else begin
                        timed_state = ST_IDLE;
                        idx_next    = '0;
                        done_next   = 1'b1;
                    end
                end else begin
                    gap_next = gap_cnt + 1'b1;
                end
            end
            ST_PAUSED: begin
                if (play_pause) timed_state = saved;
            end
        endcase
        if (load) begin
            beat_next       = '0;
            beats_left_next = entry.dur;
        end
        state_next = timed_state;
        if (play_pause && (state == ST_PLAY || state == ST_GAP) &&
            (timed_state == ST_PLAY || timed_state == ST_GAP)) begin
            state_next = ST_PAUSED;
            saved_next = timed_state;
        end
        if (stop) begin
            state_next      = ST_IDLE;
            idx_next        = '0;
            beat_next       = '0;
            gap_next        = '0;
            beats_left_next = '0;
            load            = 1'b0;
            done_next       = 1'b0;
        end
    end

    always_comb begin
        note_div_next = note_div;
        cur_mute_next = cur_mute;
        if (load) begin
            note_div_next = note_divider(entry.code, CLK_HZ);
            cur_mute_next = is_rest(entry.code);
        end
        mute_next    = (state_next == ST_PLAY) ? cur_mute_next : 1'b1;
        playing_next = (state_next == ST_PLAY) || (state_next == ST_GAP);
    end

endmodule

// File: doc/music_sequencer.md
Name: music_sequencer

Overview:
- Melody controller that drives the square-wave note generator (note_gun) by sequencing a fixed song table.
- Steps through a SONG_LEN-entry note ROM at a programmable beat rate and presents the note divider plus a mute flag for each entry.
- Inserts a short muted gap between notes and supports play/pause, stop and looping.
- Sits between the board button/switch debouncers and note_gun; mute gates note_gun's audio output at the top level.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency; used only for divider constants.
- BEAT_CYCLES, 25_000_000, clk cycles per beat (4 beats/s).
- GAP_CYCLES, 2_500_000, muted cycles inserted after every note.
- SONG_LEN, 16, number of ROM entries; index width is 4.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- play_pause  in  1  single-cycle pulse; starts from IDLE, toggles pause otherwise
- stop  in  1  single-cycle pulse; abort to IDLE
- loop_en  in  1  level; wrap to entry 0 after the last entry
- note_div  out  22  divider to note_gun; toggle period = 2*(note_div+1) clk cycles
- mute  out  1  1 = silence the audio output
- playing  out  1  1 in PLAY or GAP
- song_idx  out  4  current ROM index
- done  out  1  one-cycle pulse when the song ends without looping

Behaviour:
- Reset values (async, immediate): state IDLE, note_div=0, mute=1, playing=0, song_idx=0, done=0; all counters 0.
- All outputs are registered.
- Note code to divider mapping: note_div = CLK_HZ/(2*f) - 1, integer division, constant-folded.
  - 1=C4 262, 2=D4 294, 3=E4 330, 4=F4 349, 5=G4 392, 6=A4 440, 7=B4 494, 8=C5 523.
  - Code 0 and codes 9-15 are rest: note_div=0, mute=1.
- ROM entry is {code[3:0], dur[1:0]}; the note lasts (dur+1) beats.
- States: IDLE, PLAY, GAP, PAUSED.
- IDLE:
  - mute=1.
  - A play_pause pulse at edge T: from T+1, state=PLAY, song_idx=0, note_div/mute loaded from entry 0, beat_cnt=0, beats_left=dur.
- PLAY:
  - beat_cnt counts 0..BEAT_CYCLES-1.
  - At wrap with beats_left=0: go to GAP. Otherwise decrement beats_left.
  - Total PLAY length = (dur+1)*BEAT_CYCLES cycles.
- GAP:
  - mute=1, note_div is held; lasts GAP_CYCLES cycles.
  - At the end, if song_idx < SONG_LEN-1: increment song_idx, load the next entry, enter PLAY.
  - If song_idx = SONG_LEN-1 and loop_en=1: song_idx=0, enter PLAY.
  - If song_idx = SONG_LEN-1 and loop_en=0: enter IDLE, song_idx=0, done=1 for exactly one cycle.
  - loop_en is sampled only at this boundary.
- PAUSED:
  - Entered by play_pause in PLAY or GAP.
  - Saves the return state, freezes all counters and song_idx; mute=1, playing=0.
  - play_pause again restores the saved state with counters resumed exactly; mute is restored to the entry's value.
- stop: from any state, next cycle state=IDLE, song_idx=0, mute=1, counters cleared. done is not asserted.
- Priority: rst > stop > play_pause > internal timing events.
  - stop and play_pause in the same cycle: stop wins.
  - play_pause on the same cycle as a PLAY->GAP or GAP->PLAY boundary: the transition completes first and the pause takes effect from the new state. Neither the boundary nor the pause is lost.
- Counters: beat_cnt and gap_cnt are sized $clog2 of their parameters; no wrap beyond the terminal count.
- Reset mid-song: immediate return to reset values; there is no resume.

Decomposition:
- Shared package/include holds:
  - note code constants NOTE_REST, NOTE_C4..NOTE_C5;
  - the frequency table;
  - the state encodings (2 bits);
  - the ROM entry field widths.
- Sub-module song_rom: combinational, index[3:0] -> {code, dur}.
  - Normative entries: 0={1,0} (C4, 1 beat); 1={6,1} (A4, 2 beats); 2={0,0} (rest, 1 beat); 15={8,3} (C5, 4 beats).
  - Remaining entries are free melody content.
- Code-to-divider mapping is a function in the package.

Test Plan (CLK_HZ=100e6, BEAT_CYCLES=10, GAP_CYCLES=2):
1. Reset asserted mid-cycle -> outputs go to reset values immediately. Release, no input -> state stays IDLE, mute=1.
2. play_pause at edge T:
   - T+1..T+10: note_div=190838, mute=0, song_idx=0.
   - T+11..T+12: mute=1.
   - T+13..T+32: note_div=113635, song_idx=1.
   - T+35: idx2 rest, mute=1 for 10 cycles.
3. Pause at the 5th PLAY cycle of idx1 for 7 cycles -> mute=1 and playing=0 during the pause. After resume, idx1 plays exactly 15 more cycles.
4. stop together with play_pause during GAP -> next cycle IDLE, song_idx=0, mute=1, done stays 0.
5. Full song with loop_en=0:
   - idx15 presents note_div=95601 for 40 cycles, then 2 gap cycles.
   - Then done=1 for one cycle and state IDLE.
   - Repeat with loop_en=1 -> song_idx returns to 0 with no done pulse.
6. play_pause coincident with the PLAY->GAP boundary of idx0 -> state PAUSED with saved state GAP. Resume -> 2 gap cycles, then idx1.
